alu_share_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 36 +++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/alu_share_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and latency helpers for the ALU
// share arbiter.
package alu_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Reserved opcodes are those with bit 2 set.
    function automatic logic op_reserved(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic [3:0] op_latency(input logic [2:0]  op,
                                              input int unsigned add_cycles,
                                              input int unsigned logic_cycles);
        logic [31:0] add_w;
        logic [31:0] logic_w;
        add_w   = add_cycles;
        logic_w = logic_cycles;
        if (op_reserved(op)) begin
            return 4'd1;
        end else if (op == OP_ADD) begin
            return add_w[3:0];
        end else begin
            return logic_w[3:0];
        end
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, last-winner register
// advanced only when the grant is actually taken.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    // last_q holds the index of the most recent winner; reset to 1 so
    // master 0 is favoured first.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (en_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Sequences two masters onto one shared 8-bit ALU: captures operands on a
// req/ack handshake, holds them for the opcode's settling time, returns result.
module alu_share_arbiter #(
    parameter int unsigned ADD_CYCLES   = 2,
    parameter int unsigned LOGIC_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic [2:0] OP0,
    input  logic [2:0] OP1,
    input  logic [7:0] A0,
    input  logic [7:0] A1,
    input  logic [7:0] B0,
    input  logic [7:0] B1,
    output logic       ACK0,
    output logic       ACK1,
    output logic       DONE0,
    output logic       DONE1,
    output logic [7:0] RESULT,
    output logic       ERR,
    output logic       BUSY,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [2:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT
);

    import alu_pkg::*;

    if (ADD_CYCLES < 1 || ADD_CYCLES > 15) begin : g_bad_add_cycles
        $error("ADD_CYCLES must be within 1..15");
    end
    if (LOGIC_CYCLES < 1 || LOGIC_CYCLES > 15) begin : g_bad_logic_cycles
        $error("LOGIC_CYCLES must be within 1..15");
    end

    alu_pkg::state_t state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            win_q, win_d;
    logic [2:0]      op_q, op_d;
    logic [7:0]      a_q, a_d;
    logic [7:0]      b_q, b_d;
    logic [7:0]      result_q, result_d;
    logic [1:0]      ack_q, ack_d;
    logic [1:0]      done_q, done_d;
    logic            err_q, err_d;

    logic [1:0]      gnt;
    logic            grant_en;
    logic [2:0]      op_sel;

    rr_arbiter2 u_rr_arbiter2 (
        .clk_i (CLK),
        .rst_i (RESET),
        .req_i ({REQ1, REQ0}),
        .en_i  (grant_en),
        .gnt_o (gnt)
    );

    assign op_sel = gnt[1] ? OP1 : OP0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        ack_d    = 2'b00;
        done_d   = 2'b00;
        err_d    = 1'b0;
        grant_en = 1'b0;
        unique case (state_q)
            alu_pkg::IDLE: begin
                if (gnt != 2'b00) begin
                    grant_en = 1'b1;
                    win_d    = gnt[1];
                    op_d     = op_sel;
                    a_d      = gnt[1] ? A1 : A0;
                    b_d      = gnt[1] ? B1 : B0;
                    cnt_d    = op_latency(op_sel, ADD_CYCLES, LOGIC_CYCLES);
                    ack_d    = gnt;
                    state_d  = alu_pkg::BUSY;
                end
            end
            alu_pkg::BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    result_d = op_reserved(op_q) ? 8'h00 : ALU_RESULT;
                    err_d    = op_reserved(op_q);
                    done_d   = win_q ? 2'b10 : 2'b01;
                    state_d  = alu_pkg::IDLE;
                end
            end
            default: state_d = alu_pkg::IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= alu_pkg::IDLE;
            cnt_q    <= 4'd0;
            win_q    <= 1'b0;
            op_q     <= OP_FWD;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            result_q <= 8'h00;
            ack_q    <= 2'b00;
            done_q   <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ACK0       = ack_q[0];
    assign ACK1       = ack_q[1];
    assign DONE0      = done_q[0];
    assign DONE1      = done_q[1];
    assign ERR        = err_q;
    assign RESULT     = result_q;
    assign BUSY       = (state_q == alu_pkg::BUSY);
    assign ALU_DATA1  = a_q;
    assign ALU_DATA2  = b_q;
    // Reserved opcodes park the ALU on forward; its output is discarded.
    assign ALU_SELECT = op_reserved(op_q) ? OP_FWD : op_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations and an ADD_CYCLES=4 variant.
module tb_alu_share_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       REQ0, REQ1;
    logic [2:0] OP0, OP1;
    logic [7:0] A0, A1, B0, B1;
    logic       ACK0, ACK1, DONE0, DONE1, ERR, BUSY;
    logic [7:0] RESULT, ALU_DATA1, ALU_DATA2, ALU_RESULT;
    logic [2:0] ALU_SELECT;

    // Second instance with ADD_CYCLES=4 and its own stimulus.
    logic       req4;
    logic       req4_1;
    logic [2:0] op4;
    logic [7:0] a4, b4;
    logic       ack4_0, ack4_1, done4_0, done4_1, err4, busy4;
    logic [7:0] result4, d1_4, d2_4, alu4;
    logic [2:0] sel4;
    logic       glitch;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    // External ALU: forward passes DATA2.
    function automatic logic [7:0] alu_ref(input logic [2:0] s, input logic [7:0] x,
                                           input logic [7:0] y);
        case (s)
            3'b000:  return y;
            3'b001:  return x + y;
            3'b010:  return x & y;
            3'b011:  return x | y;
            default: return 8'h00;
        endcase
    endfunction

    assign ALU_RESULT = alu_ref(ALU_SELECT, ALU_DATA1, ALU_DATA2);
    assign alu4       = glitch ? 8'hAA : alu_ref(sel4, d1_4, d2_4);

    alu_share_arbiter dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ0       (REQ0),
        .REQ1       (REQ1),
        .OP0        (OP0),
        .OP1        (OP1),
        .A0         (A0),
        .A1         (A1),
        .B0         (B0),
        .B1         (B1),
        .ACK0       (ACK0),
        .ACK1       (ACK1),
        .DONE0      (DONE0),
        .DONE1      (DONE1),
        .RESULT     (RESULT),
        .ERR        (ERR),
        .BUSY       (BUSY),
        .ALU_DATA1  (ALU_DATA1),
        .ALU_DATA2  (ALU_DATA2),
        .ALU_SELECT (ALU_SELECT),
        .ALU_RESULT (ALU_RESULT)
    );

    alu_share_arbiter #(.ADD_CYCLES(4), .LOGIC_CYCLES(1)) dut4 (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ0       (req4),
        .REQ1       (req4_1),
        .OP0        (op4),
        .OP1        (3'b000),
        .A0         (a4),
        .A1         (8'h00),
        .B0         (b4),
        .B1         (8'h00),
        .ACK0       (ack4_0),
        .ACK1       (ack4_1),
        .DONE0      (done4_0),
        .DONE1      (done4_1),
        .RESULT     (result4),
        .ERR        (err4),
        .BUSY       (busy4),
        .ALU_DATA1  (d1_4),
        .ALU_DATA2  (d2_4),
        .ALU_SELECT (sel4),
        .ALU_RESULT (alu4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    int         cyc = 0;
    bit         inflight = 0;
    int         done_at = 0;
    bit         last_win = 1;
    bit         m_win = 0;
    logic [2:0] m_op = 3'b000;
    logic [1:0] e_ack = 0, e_done = 0;
    logic       e_err = 0, e_busy = 0;
    logic [7:0] e_result = 0, e_d1 = 0, e_d2 = 0;
    logic [2:0] e_sel = 0;

    always @(posedge CLK) begin
        cyc++;
        e_ack  = 2'b00;
        e_done = 2'b00;
        e_err  = 1'b0;
        if (RESET) begin
            inflight = 0;
            last_win = 1;
            e_result = 8'h00;
            e_d1     = 8'h00;
            e_d2     = 8'h00;
            e_sel    = 3'b000;
            m_op     = 3'b000;
        end else if (inflight) begin
            if (cyc == done_at) begin
                e_done[m_win] = 1'b1;
                e_err         = m_op[2];
                e_result      = m_op[2] ? 8'h00 : alu_ref(m_op, e_d1, e_d2);
                inflight      = 0;
            end
        end else if (REQ0 || REQ1) begin
            m_win    = (REQ0 && REQ1) ? !last_win : REQ1;
            last_win = m_win;
            m_op     = m_win ? OP1 : OP0;
            e_d1     = m_win ? A1 : A0;
            e_d2     = m_win ? B1 : B0;
            e_sel    = m_op[2] ? 3'b000 : m_op;
            e_ack[m_win] = 1'b1;
            inflight = 1;
            if (m_op[2])           done_at = cyc + 1;
            else if (m_op == 3'b001) done_at = cyc + 2;
            else                   done_at = cyc + 1;
        end
        e_busy = inflight;
    end

    always @(negedge CLK) begin
        if (cyc > 0) begin
            chk("ack0", ACK0, e_ack[0]);
            chk("ack1", ACK1, e_ack[1]);
            chk("done0", DONE0, e_done[0]);
            chk("done1", DONE1, e_done[1]);
            chk("err", ERR, e_err);
            chk("busy", BUSY, e_busy);
            chk("result", RESULT, e_result);
            chk("data1", ALU_DATA1, e_d1);
            chk("data2", ALU_DATA2, e_d2);
            chk("select", ALU_SELECT, e_sel);
            chk("one_ack", ACK0 & ACK1, 1'b0);
            chk("one_done", DONE0 & DONE1, 1'b0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input int m, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_res, input logic exp_err,
                         input int exp_lat, input logic [2:0] exp_sel);
        int k;
        bit seen;
        @(negedge CLK);
        if (m == 0) begin REQ0 = 1; OP0 = op; A0 = a; B0 = b; end
        else        begin REQ1 = 1; OP1 = op; A1 = a; B1 = b; end
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            seen = (m == 0) ? ACK0 : ACK1;
        end
        chk("ack_seen", seen, 1'b1);
        chk("sel_issued", ALU_SELECT, exp_sel);
        if (m == 0) REQ0 = 0; else REQ1 = 0;
        k = 0;
        seen = 0;
        while (!seen && k < 20) begin
            @(negedge CLK);
            k++;
            seen = (m == 0) ? DONE0 : DONE1;
        end
        chk("done_latency", k, exp_lat);
        chk("done_result", RESULT, exp_res);
        chk("done_err", ERR, exp_err);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (BUSY && k < 30) begin
            @(negedge CLK);
            k++;
        end
        chk("idle_timeout", BUSY, 1'b0);
    endtask

    int grants[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1; REQ0 = 0; REQ1 = 0; OP0 = 0; OP1 = 0; A0 = 0; A1 = 0; B0 = 0; B1 = 0;
        req4 = 0; req4_1 = 0; op4 = 0; a4 = 0; b4 = 0; glitch = 0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_result", RESULT, 8'h00);
        RESET = 0;

        issue(0, 3'b001, 8'd3, 8'd5, 8'd8, 1'b0, 2, 3'b001);
        issue(1, 3'b010, 8'd3, 8'd5, 8'd1, 1'b0, 1, 3'b010);
        issue(1, 3'b011, 8'd3, 8'd5, 8'd7, 1'b0, 1, 3'b011);
        issue(1, 3'b000, 8'd3, 8'd5, 8'd5, 1'b0, 1, 3'b000);

        // Continuous contention after a fresh reset: master 0 first, then alternate.
        @(negedge CLK);
        RESET = 1;
        @(negedge CLK);
        RESET = 0;
        REQ0 = 1; OP0 = 3'b001; A0 = 8'd10;  B0 = 8'd20;
        REQ1 = 1; OP1 = 3'b011; A1 = 8'h0F;  B1 = 8'hF0;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            if (ACK0) grants.push_back(0);
            if (ACK1) grants.push_back(1);
        end
        REQ0 = 0; REQ1 = 0;
        wait_idle();
        chk("grant_count_ge4", grants.size() >= 4, 1'b1);
        if (grants.size() >= 4) begin
            chk("grant0", grants[0], 0);
            chk("grant1", grants[1], 1);
            chk("grant2", grants[2], 0);
            chk("grant3", grants[3], 1);
        end

        issue(0, 3'b100, 8'd9, 8'd9, 8'h00, 1'b1, 1, 3'b000);
        issue(0, 3'b011, 8'h30, 8'h03, 8'h33, 1'b0, 1, 3'b011);

        // Reset one cycle after the ACK of an add.
        @(negedge CLK);
        REQ0 = 1; OP0 = 3'b001; A0 = 8'd1; B0 = 8'd1;
        for (int i = 0; i < 10 && !ACK0; i++) @(negedge CLK);
        chk("abort_ack", ACK0, 1'b1);
        REQ0 = 0;
        RESET = 1;
        @(negedge CLK);
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_result", RESULT, 8'h00);
        chk("abort_data1", ALU_DATA1, 8'h00);
        chk("abort_select", ALU_SELECT, 3'b000);
        RESET = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("abort_no_done", DONE0, 1'b0);
        end
        issue(0, 3'b001, 8'd4, 8'd4, 8'd8, 1'b0, 2, 3'b001);

        // ADD_CYCLES=4 instance, with a corrupted ALU output before the capture edge.
        @(negedge CLK);
        req4 = 1; op4 = 3'b001; a4 = 8'd200; b4 = 8'd100;
        for (int i = 0; i < 10 && !ack4_0; i++) @(negedge CLK);
        chk("add4_ack", ack4_0, 1'b1);
        req4 = 0;
        glitch = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            if (k == 3) glitch = 0;
            chk("add4_done", done4_0, (k == 4) ? 1'b1 : 1'b0);
            if (k == 4) chk("add4_result", result4, 8'd44);
        end
        chk("add4_err", err4, 1'b0);
        chk("add4_busy", busy4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
